// File: rtl/poly_oscillator.sv
// poly_oscillator: per-voice phase accumulators sharing one time-multiplexed waveform datapath.
// Optional saturating voice mixer (Mix_out/Mix_valid) is built when OSC_MIX_EN is defined.
module poly_oscillator #(
  parameter int VOICES  = 4,
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16,
  parameter int LUT_AW  = 8,
  localparam int SEL_W  = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic               Sys_clk,
  input  logic               Osc_rst,
  input  logic               Osc_ce,
  input  logic               Osc_tick,
  input  logic               Freq_wr,
  input  logic [SEL_W-1:0]   Freq_sel,
  input  logic [PHASE_W-1:0] Freq_data,
  input  logic [1:0]         Mode_data,
  output logic [OUT_W-1:0]   Wave_out,
  output logic [SEL_W-1:0]   Wave_voice,
  output logic               Wave_valid,
  output logic               Busy,
  output logic               Overrun
`ifdef OSC_MIX_EN
  ,
  output logic [OUT_W-1:0]   Mix_out,
  output logic               Mix_valid
`endif
);

  localparam int DEPTH = 1 << LUT_AW;
  localparam int CNT_W = $clog2(VOICES + 2);
  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(VOICES);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(VOICES + 1);
  localparam logic [SEL_W-1:0] LAST_VOICE = SEL_W'(VOICES - 1);
  localparam logic signed [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

  // Fixed-point (Q30) Taylor series keeps the table build integer-only at elaboration.
  function automatic logic [OUT_W-2:0] sine_entry(input int k);
    longint x, term, sum, val;
    x    = (64'sd1686629713 * longint'(2 * k + 1)) >>> (LUT_AW + 1);
    term = x;
    sum  = x;
    for (int n = 1; n <= 6; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    val = (sum * ((64'sd1 <<< (OUT_W - 1)) - 64'sd1) + 64'sd536870912) >>> 30;
    return val[OUT_W-2:0];
  endfunction

  logic [OUT_W-2:0] rom_s [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [OUT_W-2:0] ENTRY = sine_entry(k);
    assign rom_s[k] = ENTRY;
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               overrun_q, overrun_d;
  logic               accept_s, issue_s;
  logic [SEL_W-1:0]   iv_s;
  logic [PHASE_W-1:0] new_phase_s;
  logic [LUT_AW-1:0]  rom_addr_s;

  logic [PHASE_W-1:0] phase_q  [VOICES];
  logic [PHASE_W-1:0] inc_q    [VOICES];
  logic [PHASE_W-1:0] inc_sh_q [VOICES];
  logic [1:0]         mode_q   [VOICES];
  logic [1:0]         mode_sh_q[VOICES];

  logic               s1_valid_q;
  logic [SEL_W-1:0]   s1_voice_q;
  logic [1:0]         s1_mode_q;
  logic [OUT_W-1:0]   s1_p_q;
  logic [OUT_W-2:0]   s1_rom_q;

  logic signed [OUT_W-1:0] sample_s, tri_mag_s, rom_ext_s, ramp_s;
  logic [OUT_W-1:0]   wave_out_q;
  logic [SEL_W-1:0]   wave_voice_q;
  logic               wave_valid_q;

  // Sweep sequencer: one voice issued per cycle, then two cycles of pipeline drain.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    accept_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Osc_tick && Osc_ce) begin
          accept_s = 1'b1;
          state_d  = ST_SWEEP;
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (Osc_tick && Osc_ce) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Sys_clk or posedge Osc_rst) begin
    if (Osc_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    issue_s     = (state_q == ST_SWEEP) && (cnt_q < ISSUE_END);
    iv_s        = cnt_q[SEL_W-1:0];
    new_phase_s = phase_q[iv_s] + inc_q[iv_s];
    if (new_phase_s[PHASE_W-2]) begin
      rom_addr_s = ~new_phase_s[PHASE_W-3 -: LUT_AW];
    end else begin
      rom_addr_s = new_phase_s[PHASE_W-3 -: LUT_AW];
    end
  end

  // Shadow settings become active only at sweep start; same-cycle writes miss that sweep.
  always_ff @(posedge Sys_clk or posedge Osc_rst) begin
    if (Osc_rst) begin
      for (int v = 0; v < VOICES; v++) begin
        phase_q[v]   <= {PHASE_W{1'b0}};
        inc_q[v]     <= {PHASE_W{1'b0}};
        inc_sh_q[v]  <= {PHASE_W{1'b0}};
        mode_q[v]    <= 2'd0;
        mode_sh_q[v] <= 2'd0;
      end
    end else begin
      if (accept_s) begin
        for (int v = 0; v < VOICES; v++) begin
          inc_q[v]  <= inc_sh_q[v];
          mode_q[v] <= mode_sh_q[v];
        end
      end
      if (Freq_wr) begin
        inc_sh_q[Freq_sel]  <= Freq_data;
        mode_sh_q[Freq_sel] <= Mode_data;
      end
      if (issue_s) begin
        phase_q[iv_s] <= new_phase_s;
      end
    end
  end

  always_ff @(posedge Sys_clk or posedge Osc_rst) begin
    if (Osc_rst) begin
      s1_valid_q <= 1'b0;
      s1_voice_q <= {SEL_W{1'b0}};
      s1_mode_q  <= 2'd0;
      s1_p_q     <= {OUT_W{1'b0}};
      s1_rom_q   <= {(OUT_W-1){1'b0}};
    end else begin
      s1_valid_q <= issue_s;
      s1_voice_q <= iv_s;
      s1_mode_q  <= mode_q[iv_s];
      s1_p_q     <= new_phase_s[PHASE_W-1 -: OUT_W];
      s1_rom_q   <= rom_s[rom_addr_s];
    end
  end

  // Triangle: ramp doubles the in-quadrant offset; odd quadrants descend, upper half is negated.
  always_comb begin
    rom_ext_s = {1'b0, s1_rom_q};
    ramp_s    = {1'b0, s1_p_q[OUT_W-3:0], 1'b0};
    if (s1_p_q[OUT_W-2]) begin
      tri_mag_s = POS_MAX - ramp_s;
    end else begin
      tri_mag_s = ramp_s;
    end
    case (s1_mode_q)
      2'd0:    sample_s = s1_p_q[OUT_W-1] ? -rom_ext_s : rom_ext_s;
      2'd1:    sample_s = {~s1_p_q[OUT_W-1], s1_p_q[OUT_W-2:0]};
      2'd2:    sample_s = s1_p_q[OUT_W-1] ? NEG_MAX : POS_MAX;
      2'd3:    sample_s = s1_p_q[OUT_W-1] ? -tri_mag_s : tri_mag_s;
      default: sample_s = {OUT_W{1'b0}};
    endcase
  end

  always_ff @(posedge Sys_clk or posedge Osc_rst) begin
    if (Osc_rst) begin
      wave_out_q   <= {OUT_W{1'b0}};
      wave_voice_q <= {SEL_W{1'b0}};
      wave_valid_q <= 1'b0;
    end else begin
      wave_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        wave_out_q   <= sample_s;
        wave_voice_q <= s1_voice_q;
      end
    end
  end

  assign Wave_out   = wave_out_q;
  assign Wave_voice = wave_voice_q;
  assign Wave_valid = wave_valid_q;
  assign Busy       = (state_q == ST_SWEEP);
  assign Overrun    = overrun_q;

`ifdef OSC_MIX_EN
  localparam int ACC_W = OUT_W + 5;
  localparam logic signed [ACC_W-1:0] ACC_HI = {{6{1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_LO = {{5{1'b1}}, 1'b1, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q, acc_d, sample_ext_s;
  logic [OUT_W-1:0]        mix_out_q, mix_out_d;
  logic                    mix_valid_q, mix_valid_d;

  // Voice 0 restarts the sum; the mix is published the cycle after the last voice's sample.
  always_comb begin
    sample_ext_s = {{5{sample_s[OUT_W-1]}}, sample_s};
    acc_d        = acc_q;
    mix_out_d    = mix_out_q;
    mix_valid_d  = 1'b0;
    if (s1_valid_q) begin
      if (s1_voice_q == {SEL_W{1'b0}}) begin
        acc_d = sample_ext_s;
      end else begin
        acc_d = acc_q + sample_ext_s;
      end
    end else begin
      acc_d = acc_q;
    end
    if (wave_valid_q && (wave_voice_q == LAST_VOICE)) begin
      mix_valid_d = 1'b1;
      if (acc_q > ACC_HI) begin
        mix_out_d = POS_MAX;
      end else if (acc_q < ACC_LO) begin
        mix_out_d = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        mix_out_d = acc_q[OUT_W-1:0];
      end
    end else begin
      mix_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Sys_clk or posedge Osc_rst) begin
    if (Osc_rst) begin
      acc_q       <= {ACC_W{1'b0}};
      mix_out_q   <= {OUT_W{1'b0}};
      mix_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  assign Mix_out   = mix_out_q;
  assign Mix_valid = mix_valid_q;
`endif

endmodule

// File: doc/poly_oscillator.md
# poly_oscillator

Parametrised multi-voice, multi-waveform oscillator, the next generation of the synthesizer's single-voice sine oscillator. It holds one phase accumulator per voice and advances every voice once per synthesis tick. A single shared waveform datapath is time-multiplexed across the voices, and each voice selects sine, saw, square or triangle. It sits between the note/frequency control logic and the envelope/mixer stage, all in the `Sys_clk` domain.

## Interface
- `VOICES`, 4: number of voices; must be a power of two, 1–16.
- `PHASE_W`, 32: phase accumulator and frequency increment width.
- `OUT_W`, 16: sample width, signed two's complement.
- `LUT_AW`, 8: quarter-wave sine table address width (2^LUT_AW entries).
- `Sys_clk`  in  1: system clock (100 MHz); the only clock.
- `Osc_rst`  in  1: reset, asynchronous, active-high.
- `Osc_ce`  in  1: active-high enable; when low, ticks are ignored.
- `Osc_tick`  in  1: single-cycle synthesis-rate strobe (1 MHz).
- `Freq_wr`  in  1: write strobe for voice settings.
- `Freq_sel`  in  clog2(VOICES) (min 1): voice index for the write.
- `Freq_data`  in  PHASE_W: phase increment per tick.
- `Mode_data`  in  2: 0 sine, 1 saw, 2 square, 3 triangle.
- `Wave_out`  out  OUT_W: sample for voice `Wave_voice`.
- `Wave_voice`  out  clog2(VOICES): voice index of `Wave_out`.
- `Wave_valid`  out  1: `Wave_out` is valid this cycle.
- `Busy`  out  1: a sweep is in progress.
- `Overrun`  out  1: sticky flag, set when a tick is dropped.
- `Mix_out`  out  OUT_W: saturated voice sum; present only with `OSC_MIX_EN`.
- `Mix_valid`  out  1: present only with `OSC_MIX_EN`.

## Operation
- Per-voice state: `phase[v]` (PHASE_W), active `inc[v]` and `mode[v]`, and shadow `inc_s[v]` and `mode_s[v]`.
- Writes: `Freq_wr` writes `Freq_data` and `Mode_data` into the shadow registers for voice `Freq_sel`. Writes are accepted on any cycle, including while `Busy` is high.
- Sweep start: `Osc_tick` with `Osc_ce` high and `Busy` low starts a sweep. In that cycle, every active register loads from its shadow register.
  - A write in the same cycle lands in the shadow only and takes effect at the next sweep.
- Dropped tick: `Osc_tick` while `Busy` is high is ignored and sets `Overrun`. Only reset clears `Overrun`.
- Idle hold: with `Osc_ce` low, no sweep starts and phases hold. An in-flight sweep still completes.
- Issue order: the sweep issues voices 0..VOICES-1, one per cycle. For each voice, `phase[v] <= phase[v] + inc[v]` (mod 2^PHASE_W, wraps silently), and the waveform is computed from the updated phase.
- Waveform source: let `p` = updated `phase[PHASE_W-1 -: OUT_W]` and `M` = 2^(OUT_W-1) - 1.
  - Saw: `p` with its MSB inverted, read as signed. Range -2^(OUT_W-1)..M.
  - Square: `+M` if the phase MSB is 0, else `-M`.
  - Triangle: fold `p` at its half and quarter points into the range -M..+M. The peak `+M` is at p = 2^(OUT_W-2).
  - Sine: quarter-wave ROM entry k = round(M · sin(π/2 · (k+0.5)/2^LUT_AW)). The ROM is built at elaboration, and the address uses the phase bits below the top two. Quadrant bits mirror the address and negate the result.
- Sample order: each voice produces exactly one `Wave_valid` pulse per sweep, in ascending voice order.
- Reset: `Osc_rst` clears all phases, increments (active and shadow), modes (so sine), `Wave_out`, `Wave_voice`, `Wave_valid`, `Busy`, `Overrun`, `Mix_out` and `Mix_valid` to 0. A reset asserted mid-sweep aborts the sweep; no further `Wave_valid` follows.

## Timing
- Timing reference: tick accepted at cycle T.
- `Busy`: high from T+1 through T+VOICES+2 inclusive.
- Voice issue: voice v is issued at T+1+v, and its phase register holds the updated value from T+2+v.
- Samples: registered ROM read plus output register give `Wave_valid` with `Wave_voice = v` at T+3+v. `Wave_out` holds its last value between valid pulses.
- Next sweep: the earliest next accepted tick is T+VOICES+3.
- Sweep rate: `VOICES` ≤ 16 keeps one sweep well inside a 1 MHz tick period at 100 MHz.

## Configuration
- `OSC_MIX_EN` defined:
  - An accumulator sums the sign-extended samples of one sweep.
  - `Mix_out` is the sum saturated to [-2^(OUT_W-1), M], with a `Mix_valid` pulse at T+VOICES+3.
  - `Mix_out` holds between pulses and resets to 0.
- `OSC_MIX_EN` undefined: `Mix_out`, `Mix_valid` and the accumulator are absent.

## Test plan
- Reset state: assert `Osc_rst` mid-sweep (cycle T+2, `VOICES=4`) → all outputs are 0 immediately, and there is no `Wave_valid` until the next accepted tick.
- Saw stepping: voice 0 saw with `Freq_data=0x4000_0000`, three ticks (defaults) → voice-0 samples are 0xC000, 0x0000, 0x4000, and phase wraps to 0 on the fourth tick.
- Square and sine: voice 1 square and voice 2 sine, both `0x4000_0000`; after one tick → voice 2 = 0x7FFF (±1 LSB); after two ticks → voice 1 = 0x8001.
- Tick spacing: tick at T, then at T+2 → second tick dropped, `Overrun`=1, `Wave_valid` pulses at T+3..T+6 only; a tick at T+7 is accepted.
- Shadow timing: `Freq_wr` at T+1 with a new increment → the current sweep uses the old increment and the next sweep uses the new one; a write coincident with tick T also applies only from the next sweep.
- Mixer (with `OSC_MIX_EN`): four voices square at the same phase (MSB 0) → `Mix_out`=0x7FFF (saturated), `Mix_valid` at T+7.
